// File: rtl/pipe_ctrl_stage.sv
// Registered RV32 main decoder with the ID/EX control latch, stall/flush, and a halt drain FSM.
// Optional macro CTRL_ILLEGAL_TRAP_EN: unknown opcodes set sticky illegal_op and drain like HALT.
module pipe_ctrl_stage #(
  parameter int OPCODE_W     = 7,
  parameter int ALUOP_W      = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic                stall,
  input  logic                flush,
  output logic                ex_valid,
  output logic                ex_alusrc,
  output logic                ex_memtoreg,
  output logic                ex_regwrite,
  output logic                ex_memread,
  output logic                ex_memwrite,
  output logic                ex_branch,
  output logic                ex_jump,
  output logic                ex_jumpreg,
  output logic [ALUOP_W-1:0]  ex_aluop,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic                illegal_op,
`endif
  output logic                fetch_hold,
  output logic                halted
);

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OP_I    = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(7'b1101111);
  localparam logic [OPCODE_W-1:0] OP_JALR = OPCODE_W'(7'b1100111);
  localparam logic [OPCODE_W-1:0] OP_LUI  = OPCODE_W'(7'b0110111);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(7'b1111111);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic                 d_alusrc, d_memtoreg, d_regwrite, d_memread;
  logic                 d_memwrite, d_branch, d_jump, d_jumpreg;
  logic [ALUOP_W-1:0]   d_aluop;
  logic                 known;
  logic                 is_halt;
  logic                 trap_op;
  logic                 accept;
  logic                 take_trap;
  logic                 load_real;

  always_comb begin
    d_alusrc   = 1'b0;
    d_memtoreg = 1'b0;
    d_regwrite = 1'b0;
    d_memread  = 1'b0;
    d_memwrite = 1'b0;
    d_branch   = 1'b0;
    d_jump     = 1'b0;
    d_jumpreg  = 1'b0;
    d_aluop    = '0;
    known      = 1'b1;
    case (id_opcode)
      OP_R:    begin d_regwrite = 1'b1; d_aluop = ALUOP_W'(2'b10); end
      OP_LW:   begin
        d_alusrc = 1'b1; d_memtoreg = 1'b1; d_regwrite = 1'b1; d_memread = 1'b1;
      end
      OP_SW:   begin d_alusrc = 1'b1; d_memwrite = 1'b1; end
      OP_BR:   begin d_branch = 1'b1; d_aluop = ALUOP_W'(2'b01); end
      OP_I:    begin d_alusrc = 1'b1; d_regwrite = 1'b1; d_aluop = ALUOP_W'(2'b11); end
      OP_JAL:  begin d_regwrite = 1'b1; d_jump = 1'b1; end
      OP_JALR: begin d_alusrc = 1'b1; d_regwrite = 1'b1; d_jump = 1'b1; d_jumpreg = 1'b1; end
      OP_LUI:  begin d_alusrc = 1'b1; d_regwrite = 1'b1; end
      OP_HALT: ;
      default: known = 1'b0;
    endcase
  end

  assign is_halt = (id_opcode == OP_HALT);
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign trap_op = is_halt | ~known;
`else
  assign trap_op = is_halt;
`endif
  assign accept    = (state == RUN) & ~trap_op;
  assign take_trap = (state == RUN) & id_valid & trap_op & ~stall & ~flush;
  assign load_real = id_valid & accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch   <= 1'b0;
      ex_jump     <= 1'b0;
      ex_jumpreg  <= 1'b0;
      ex_aluop    <= '0;
    end else if (flush || !stall) begin
      // flush and a gated load both reduce to "load, masked by load_real"
      ex_valid    <= ~flush & load_real;
      ex_alusrc   <= ~flush & load_real & d_alusrc;
      ex_memtoreg <= ~flush & load_real & d_memtoreg;
      ex_regwrite <= ~flush & load_real & d_regwrite;
      ex_memread  <= ~flush & load_real & d_memread;
      ex_memwrite <= ~flush & load_real & d_memwrite;
      ex_branch   <= ~flush & load_real & d_branch;
      ex_jump     <= ~flush & load_real & d_jump;
      ex_jumpreg  <= ~flush & load_real & d_jumpreg;
      ex_aluop    <= (~flush & load_real) ? d_aluop : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      cnt        <= '0;
      fetch_hold <= 1'b0;
      halted     <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_op <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          if (take_trap) begin
            state      <= DRAIN;
            cnt        <= 4'(DRAIN_CYCLES - 1);
            fetch_hold <= 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
            if (!is_halt) illegal_op <= 1'b1;
`endif
          end
        end
        DRAIN: begin
          if (flush) begin
            state      <= RUN;
            cnt        <= '0;
            fetch_hold <= 1'b0;
          end else if (cnt == '0) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HALTED: begin
          fetch_hold <= 1'b1;
          halted     <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/pipe_ctrl_stage.md
Name: pipe_ctrl_stage

Overview:
- Registered successor to the combinational RV32 main decoder.
- Decodes the ID-stage opcode and latches the control bundle into the ID/EX boundary.
- Supports stall (hold) and flush (bubble insertion).
- Adds a halt state machine that drains the pipeline before freezing fetch.
- Sits between the IF/ID register and the EX stage; the hazard unit drives stall/flush.

Parameters:
- OPCODE_W, 7, opcode field width; fixed at 7 for RV32 encodings.
- ALUOP_W, 2, ALUOp field width to the ALU decoder.
- DRAIN_CYCLES, 3, cycles after halt acceptance before halted asserts; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  OPCODE_W  opcode field of the ID instruction.
- stall  in  1  hold ID/EX contents; ID does not advance.
- flush  in  1  replace the ID/EX contents with a bubble; cancels a pending halt.
- ex_valid  out  1  EX stage holds a real instruction.
- ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jump, ex_jumpreg  out  1 each  registered control bits.
- ex_aluop  out  ALUOP_W  00 add (LW/SW/JAL/JALR/LUI), 01 branch, 10 R-type, 11 I-type ALU.
- illegal_op  out  1  sticky flag for an unknown opcode; exists only with the optional feature.
- fetch_hold  out  1  freeze PC/IF-ID while a halt drains or after halt.
- halted  out  1  core halted; sticky until reset.

Behaviour:
- Decode table, combinational on id_opcode:
  - R 0110011: regwrite, aluop 10.
  - LW 0000011: alusrc, memtoreg, regwrite, memread, aluop 00.
  - SW 0100011: alusrc, memwrite, aluop 00.
  - BR 1100011: branch, aluop 01.
  - I 0010011: alusrc, regwrite, aluop 11.
  - JAL 1101111: regwrite, jump, aluop 00.
  - JALR 1100111: alusrc, regwrite, jump, jumpreg, aluop 00.
  - LUI 0110111: alusrc, regwrite, aluop 00.
  - HALT 1111111: no control bits set.
  - Any other opcode: all control bits zero.
- Reset (rst_n low, asynchronous): all ex_* outputs 0, fetch_hold 0, halted 0, illegal_op 0, FSM RUN, drain counter 0.
- Register update priority each clk edge: flush > stall > load.
  - flush: ex_valid and all control bits load 0.
  - stall with no flush: hold every ex_* output.
  - load: ex_valid <= id_valid & accept; control bits loaded, then gated to 0 when not id_valid or not accepted.
- Latency: one cycle from id_opcode to ex_* outputs.
- Accept condition: FSM in RUN and opcode is not HALT. A HALT opcode, and anything arriving in DRAIN or HALTED, loads as a bubble.
- FSM states: RUN, DRAIN, HALTED.
  - RUN -> DRAIN: id_valid, opcode HALT, no stall, no flush. Counter <= DRAIN_CYCLES-1; fetch_hold asserts the following cycle.
  - DRAIN: counter decrements every cycle, stall is ignored. When counter==0 and no flush -> HALTED.
  - DRAIN + flush (an older branch redirected past the halt): -> RUN, counter cleared, fetch_hold drops next cycle.
  - HALTED: halted=1 and fetch_hold=1; stall and flush have no effect; exits only via rst_n.
- Simultaneous HALT in ID and flush in RUN: flush wins; FSM stays in RUN.
- Reset asserted mid-DRAIN: immediate return to RUN with all outputs cleared.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - A valid, accepted, unknown opcode in RUN sets illegal_op (sticky).
  - That instruction loads as a bubble and the FSM follows the DRAIN path exactly as for HALT.
- Undefined:
  - illegal_op port is absent.
  - Unknown opcodes load with ex_valid=1 and all control bits 0, i.e. a NOP.

Test Plan:
- Reset then id_valid=1, opcode 0000011 -> next cycle ex_valid=1, alusrc=memtoreg=regwrite=memread=1, aluop=00, others 0.
- Opcode 0010011, then stall=1 for 3 cycles with id_opcode 0100011 -> I-type bundle (aluop 11) held all 3 cycles, then SW bundle (memwrite=1) once stall drops.
- Opcode 1100011 with flush=1 on the same edge -> ex_valid=0, all control bits 0.
- HALT accepted with DRAIN_CYCLES=3 -> fetch_hold=1 next cycle, halted=1 exactly 3 cycles after fetch_hold rises; later stall/flush leave halted=1 and fetch_hold=1.
- HALT accepted, then flush during the 2nd DRAIN cycle -> FSM back to RUN, fetch_hold=0 next cycle, halted never asserts.
- With CTRL_ILLEGAL_TRAP_EN: opcode 0001011 valid -> illegal_op=1, ex_valid=0, halted after DRAIN_CYCLES. Without the macro: ex_valid=1, all control bits 0, no halt.
